ifu_fetch: RTL and testbench

- Instruction fetch unit, directly upstream of the decode stage; it supplies the 32-bit `inst` word that decode consumes.
- Holds the PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel plus a response-valid channel.
- Buffers returned words with their PCs in a small FIFO, presented to decode over a valid/ready handshake.
- Accepts a redirect (jump/branch) from downstream that flushes in-flight and buffered fetches.

---
 rtl/ifu_fetch.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding decode.
// Holds the PC and keeps at most one request outstanding to instruction memory.
// Returned words are buffered with their PCs in a small FIFO that decode drains
// over a valid/ready handshake. A redirect flushes buffered and in-flight fetches.
// Optional build macro IFU_PERF_CNT_EN adds the fetch and stall counters.
module ifu_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int unsigned           PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned           CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic [DATA_WIDTH-1:0] r_buf_inst [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_empty;
  logic                  w_handshake;
  logic                  w_resp_wait;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_redirect_target;

  // Handshake, push/pop qualification and the post-cycle occupancy
  always_comb begin
    w_empty           = (r_count == '0);
    w_handshake       = (r_state == S_REQ) && imem_req_ready;
    w_resp_wait       = (r_state == S_WAIT) && imem_resp_valid;
    // A response coinciding with a redirect belongs to the abandoned path
    w_push            = w_resp_wait && !redirect_valid;
    // A pop alongside a redirect is swallowed by the flush
    w_pop             = !w_empty && inst_ready && !redirect_valid;
    w_redirect_target = redirect_pc & ALIGN_MASK;
    w_count_next      = r_count;
    if (w_push) w_count_next = w_count_next + CNT_W'(1);
    if (w_pop)  w_count_next = w_count_next - CNT_W'(1);
  end

  // Outputs derived from registered state only
  always_comb begin
    imem_req_valid = (r_state == S_REQ);
    imem_req_addr  = r_pc;
    inst_valid     = !w_empty;
    inst           = w_empty ? '0 : r_buf_inst[r_rptr];
    inst_pc        = w_empty ? '0 : r_buf_pc[r_rptr];
  end

  // Buffer storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_wptr] <= imem_resp_data;
      r_buf_pc[r_wptr]   <= r_req_pc;
    end
  end

  // Fetch FSM, PC and FIFO bookkeeping; redirect overrides normal sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc    <= w_redirect_target;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      // A request accepted this cycle, or one still in flight, must be drained
      case (r_state)
        S_IDLE:  r_state <= S_REQ;
        S_REQ:   r_state <= imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  r_state <= imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  r_state <= imem_resp_valid ? S_REQ : S_DROP;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_next;
      case (r_state)
        S_IDLE: begin
          if (r_count < DEPTH_C) r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_handshake) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) r_state <= (w_count_next < DEPTH_C) ? S_REQ : S_IDLE;
        end
        S_DROP: begin
          if (imem_resp_valid) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters survive redirects and wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (inst_ready && w_empty) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table, hand-written reset sequence and a
// randomized run against a transaction-level memory and decode scoreboard.
module tb_ifu_fetch;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu_fetch #(
    .DATA_WIDTH(32),
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        redir;
    logic [31:0] rpc;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic ir, input logic redir, input logic [31:0] rpc,
                              input logic e_reqv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ir = ir; v.redir = redir; v.rpc = rpc;
    v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  initial begin
    vec_t        tbl[$];
    ent_t        q[$];
    logic        pend_valid;
    logic        pend_stale;
    logic [31:0] pend_addr;
    int          pend_due;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        hs;
    logic        pop;
    int          pops;
    int          waited;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    // cycle-by-cycle vectors: inputs for the coming edge, outputs expected now
    tbl.push_back(mk(1,0,0,1,0,0,                           0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,                           1,32'h8000_0000,0,0,0));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0000),1,0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,                           1,32'h8000_0004,1,mem_word(32'h8000_0000),32'h8000_0000));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0004),1,0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,                           1,32'h8000_0008,1,mem_word(32'h8000_0004),32'h8000_0004));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0008),0,0,0,     0,0,1,mem_word(32'h8000_0004),32'h8000_0004));
    tbl.push_back(mk(1,0,0,0,0,0,                           0,0,1,mem_word(32'h8000_0004),32'h8000_0004));
    tbl.push_back(mk(1,0,0,0,0,0,                           0,0,1,mem_word(32'h8000_0004),32'h8000_0004));
    tbl.push_back(mk(1,0,0,1,0,0,                           0,0,1,mem_word(32'h8000_0004),32'h8000_0004));
    tbl.push_back(mk(1,0,0,0,0,0,                           0,0,1,mem_word(32'h8000_0008),32'h8000_0008));
    tbl.push_back(mk(0,0,0,0,0,0,                           1,32'h8000_000C,1,mem_word(32'h8000_0008),32'h8000_0008));
    tbl.push_back(mk(0,0,0,0,0,0,                           1,32'h8000_000C,1,mem_word(32'h8000_0008),32'h8000_0008));
    tbl.push_back(mk(1,0,0,0,0,0,                           1,32'h8000_000C,1,mem_word(32'h8000_0008),32'h8000_0008));
    tbl.push_back(mk(0,0,0,1,1,32'h8000_0100,               0,0,1,mem_word(32'h8000_0008),32'h8000_0008));
    tbl.push_back(mk(0,0,0,1,0,0,                           0,0,0,0,0));
    tbl.push_back(mk(0,1,mem_word(32'h8000_000C),1,0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0,                           1,32'h8000_0100,0,0,0));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0100),0,0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,                           1,32'h8000_0104,1,mem_word(32'h8000_0100),32'h8000_0100));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0104),0,1,32'h8000_0102, 0,0,1,mem_word(32'h8000_0100),32'h8000_0100));
    tbl.push_back(mk(0,0,0,0,1,32'h8000_0200,               1,32'h8000_0100,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h8000_0300,               1,32'h8000_0200,0,0,0));
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,1,32'h8000_0404,   0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,                           1,32'h8000_0404,0,0,0));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0404),0,0,0,     0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,                           1,32'h8000_0408,1,mem_word(32'h8000_0404),32'h8000_0404));
    tbl.push_back(mk(0,1,mem_word(32'h8000_0408),0,0,0,     0,0,1,mem_word(32'h8000_0404),32'h8000_0404));
    tbl.push_back(mk(0,0,0,0,1,32'h8000_0800,               0,0,1,mem_word(32'h8000_0404),32'h8000_0404));
    tbl.push_back(mk(0,0,0,0,0,0,                           1,32'h8000_0800,0,0,0));

    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst             = 1'b0;
      imem_req_ready  = tbl[i].rdy;
      imem_resp_valid = tbl[i].rv;
      imem_resp_data  = tbl[i].rdata;
      inst_ready      = tbl[i].ir;
      redirect_valid  = tbl[i].redir;
      redirect_pc     = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d.req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_reqv));
      if (tbl[i].e_reqv) chk($sformatf("v%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      chk($sformatf("v%0d.inst", i), inst, tbl[i].e_inst);
      chk($sformatf("v%0d.inst_pc", i), inst_pc, tbl[i].e_ipc);
    end

    // reset while a response is arriving in WAIT with one entry buffered
    @(negedge clk); imem_req_ready = 1'b1; imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = mem_word(32'h8000_0800);
    @(negedge clk); imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
    @(negedge clk); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    chk("pre_rst.inst_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_resp_valid = 1'b0;
    #1;
    chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst.inst_valid", 32'(inst_valid), 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_pc", inst_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst.perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst.perf_stall", perf_stall_cnt, 32'd0);
`endif
    waited = 0;
    while (!imem_req_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("rst.req_seen", 32'(imem_req_valid), 32'd1);
    chk("rst.first_addr", imem_req_addr, RST_PC);

    // randomized run against the memory/decode scoreboard
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    pend_valid = 1'b0; pend_stale = 1'b0; pend_addr = '0; pend_due = 0;
    exp_pc = RST_PC; pops = 0; m_fetch = '0; m_stall = '0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst             = 1'b0;
      imem_req_ready  = ($urandom_range(0, 9) < 7);
      inst_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 99) < 3);
      redirect_pc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      imem_resp_valid = pend_valid && (n >= pend_due);
      imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : $urandom;
      tgt             = redirect_pc & 32'hFFFF_FFFC;
      #1;
      if (imem_req_valid) begin
        chk("rnd.req_addr", imem_req_addr, exp_pc);
        chk("rnd.one_outstanding", 32'(pend_valid), 32'd0);
      end
      chk("rnd.inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      if (!inst_valid) begin
        chk("rnd.idle_inst", inst, 32'd0);
        chk("rnd.idle_pc", inst_pc, 32'd0);
      end
`ifdef IFU_PERF_CNT_EN
      chk("rnd.perf_fetch", perf_fetch_cnt, m_fetch);
      chk("rnd.perf_stall", perf_stall_cnt, m_stall);
`endif
      hs  = imem_req_valid && imem_req_ready;
      pop = inst_valid && inst_ready && !redirect_valid;
      if (inst_ready && !inst_valid) m_stall++;
      if (pop && q.size() != 0) begin
        chk("rnd.pop_pc", inst_pc, q[0].pc);
        chk("rnd.pop_inst", inst, q[0].data);
        void'(q.pop_front());
        pops++;
      end
      if (imem_resp_valid) begin
        pend_valid = 1'b0;
        if (!pend_stale && !redirect_valid) begin
          q.push_back('{pc: pend_addr, data: imem_resp_data});
          m_fetch++;
        end
      end
      if (hs) begin
        pend_valid = 1'b1;
        pend_addr  = exp_pc;
        pend_due   = n + int'($urandom_range(1, 4));
        pend_stale = redirect_valid;
        exp_pc     = redirect_valid ? tgt : exp_pc + 32'd4;
      end else if (redirect_valid) begin
        exp_pc = tgt;
        if (pend_valid) pend_stale = 1'b1;
      end
      if (redirect_valid) q.delete();
      chk("rnd.fifo_bound", 32'(q.size() <= DEPTH), 32'd1);
    end
    chk("rnd.progress", 32'(pops > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
